// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM generator with shadowed period/duty applied at period boundaries
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] cnt,
    output logic             pwm_out,
    output logic             wrap,
    output logic             pending
);

    logic [WIDTH-1:0] cnt_q,      cnt_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic [WIDTH-1:0] duty_q,     duty_d;
    logic [WIDTH-1:0] period_s_q, period_s_d;
    logic [WIDTH-1:0] duty_s_q,   duty_s_d;
    logic             pending_q,  pending_d;

    logic handshake;
    logic apply;

    assign cfg_ready = !pending_q;
    assign handshake = cfg_valid && !pending_q;
    assign wrap      = en && (cnt_q == period_q);
    // Shadow moves to active only at a period end or while stopped, never mid-period.
    assign apply     = pending_q && (wrap || !en);

    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        duty_d     = duty_q;
        period_s_d = period_s_q;
        duty_s_d   = duty_s_q;
        pending_d  = pending_q;

        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end

        if (apply) begin
            period_d  = period_s_q;
            duty_d    = duty_s_q;
            pending_d = 1'b0;
            if (!en) begin
                cnt_d = '0;
            end
        end else if (handshake) begin
            period_s_d = cfg_period;
            duty_s_d   = cfg_duty;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q      <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            period_s_q <= '0;
            duty_s_q   <= '0;
            pending_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            period_s_q <= period_s_d;
            duty_s_q   <= duty_s_d;
            pending_q  <= pending_d;
        end
    end

    assign cnt     = cnt_q;
    assign pending = pending_q;
    assign pwm_out = (cnt_q < duty_q);

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed scoreboard bench for pwm_gen
module tb_pwm_gen;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic [7:0] cnt;
    logic       pwm_out;
    logic       wrap;
    logic       pending;

    pwm_gen #(.WIDTH(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cnt        (cnt),
        .pwm_out    (pwm_out),
        .wrap       (wrap),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cnt;
        logic       pwm;
        logic       pend;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state, advanced once per tick from the driven inputs.
    logic [7:0] m_cnt, m_per, m_duty, m_ps, m_ds;
    logic       m_pend;
    logic       m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t       e;
        logic       w;
        logic [7:0] n_cnt;
        #1;
        if (m_known) begin
            chk("wrap", {31'd0, wrap}, {31'd0, en && (m_cnt == m_per)});
            chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
        end
        if (!rstn) begin
            m_cnt = 0; m_per = 0; m_duty = 0; m_ps = 0; m_ds = 0; m_pend = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            w     = en && (m_cnt == m_per);
            n_cnt = m_cnt;
            if (en) n_cnt = w ? 8'd0 : m_cnt + 8'd1;
            if (m_pend && (w || !en)) begin
                m_per  = m_ps;
                m_duty = m_ds;
                m_pend = 1'b0;
                if (!en) n_cnt = 8'd0;
            end else if (cfg_valid && !m_pend) begin
                m_ps   = cfg_period;
                m_ds   = cfg_duty;
                m_pend = 1'b1;
            end
            m_cnt = n_cnt;
        end
        if (m_known) begin
            e.cnt  = m_cnt;
            e.pwm  = (m_cnt < m_duty);
            e.pend = m_pend;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_cnt", {24'd0, cnt}, {24'd0, e.cnt});
            chk("sb_pwm", {31'd0, pwm_out}, {31'd0, e.pwm});
            chk("sb_pending", {31'd0, pending}, {31'd0, e.pend});
        end
    endtask

    task automatic offer(input logic [7:0] per, input logic [7:0] duty);
        chk("offer_ready", {31'd0, cfg_ready}, 32'd1);
        cfg_period = per;
        cfg_duty   = duty;
        cfg_valid  = 1'b1;
        tick();
        cfg_valid  = 1'b0;
        chk("offer_pending", {31'd0, pending}, 32'd1);
    endtask

    task automatic wait_apply();
        int n = 0;
        while (pending !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("apply_timeout", {31'd0, pending}, 32'd0);
    endtask

    task automatic run_to(input logic [7:0] target);
        int n = 0;
        while (cnt !== target && n < 300) begin
            tick();
            n++;
        end
        chk("run_to_timeout", {24'd0, cnt}, {24'd0, target});
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        tick();
        tick();
        chk("rst_cnt", {24'd0, cnt}, 32'd0);
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_wrap_en0", {31'd0, wrap}, 32'd0);

        // Period 0 after reset: wrap every enabled cycle, config applied at first wrap.
        rstn = 1'b1; en = 1'b1;
        #1;
        chk("p0_wrap", {31'd0, wrap}, 32'd1);
        offer(8'd4, 8'd2);
        tick();
        chk("s1_applied", {31'd0, pending}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("s1_cnt", {24'd0, cnt}, i % 5);
            chk("s1_pwm", {31'd0, pwm_out}, ((i % 5) < 2) ? 32'd1 : 32'd0);
            chk("s1_wrap", {31'd0, wrap}, ((i % 5) == 4) ? 32'd1 : 32'd0);
            tick();
        end

        // Duty change offered mid-period is held back until the wrap.
        offer(8'd9, 8'd3);
        wait_apply();
        run_to(8'd5);
        offer(8'd9, 8'd7);
        chk("s2_ready_low", {31'd0, cfg_ready}, 32'd0);
        for (int i = 6; i <= 9; i++) begin
            chk("s2_old_cnt", {24'd0, cnt}, i);
            chk("s2_old_pwm", {31'd0, pwm_out}, 32'd0);
            tick();
        end
        chk("s2_applied", {31'd0, pending}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("s2_new_pwm", {31'd0, pwm_out}, (i < 7) ? 32'd1 : 32'd0);
            if (i == 1) chk("s2_ready_cnt1", {31'd0, cfg_ready}, 32'd1);
            tick();
        end

        // Duty extremes.
        offer(8'd9, 8'd0);
        wait_apply();
        for (int i = 0; i < 30; i++) begin
            chk("duty0_pwm", {31'd0, pwm_out}, 32'd0);
            tick();
        end
        offer(8'd9, 8'd10);
        wait_apply();
        for (int i = 0; i < 12; i++) begin
            chk("duty10_pwm", {31'd0, pwm_out}, 32'd1);
            tick();
        end
        offer(8'd9, 8'd255);
        wait_apply();
        for (int i = 0; i < 12; i++) begin
            chk("duty255_pwm", {31'd0, pwm_out}, 32'd1);
            tick();
        end

        // Stopped counter: config applies immediately and restarts from 0.
        run_to(8'd6);
        en = 1'b0;
        offer(8'd3, 8'd1);
        chk("s4_hold_cnt", {24'd0, cnt}, 32'd6);
        tick();
        chk("s4_pending", {31'd0, pending}, 32'd0);
        chk("s4_cnt", {24'd0, cnt}, 32'd0);
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("s4_seq_cnt", {24'd0, cnt}, i % 4);
            chk("s4_seq_pwm", {31'd0, pwm_out}, ((i % 4) == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Back-to-back configs: second stalls until the first is applied.
        offer(8'd5, 8'd1);
        cfg_period = 8'd2; cfg_duty = 8'd2; cfg_valid = 1'b1;
        #1;
        chk("s5_stall", {31'd0, cfg_ready}, 32'd0);
        begin
            int n = 0;
            while (pending !== 1'b0 && n < 40) begin
                tick();
                n++;
            end
        end
        chk("s5_first_applied", {31'd0, pending}, 32'd0);
        chk("s5_first_cnt", {24'd0, cnt}, 32'd0);
        tick();
        cfg_valid = 1'b0;
        chk("s5_second_taken", {31'd0, pending}, 32'd1);
        wait_apply();
        for (int i = 0; i < 6; i++) begin
            chk("s5_seq_cnt", {24'd0, cnt}, i % 3);
            chk("s5_seq_pwm", {31'd0, pwm_out}, ((i % 3) < 2) ? 32'd1 : 32'd0);
            tick();
        end

        // Reset with a pending shadow discards it.
        offer(8'd9, 8'd3);
        wait_apply();
        run_to(8'd6);
        offer(8'd2, 8'd1);
        chk("s6_cnt7", {24'd0, cnt}, 32'd7);
        rstn = 1'b0;
        tick();
        chk("s6_cnt", {24'd0, cnt}, 32'd0);
        chk("s6_pending", {31'd0, pending}, 32'd0);
        chk("s6_pwm", {31'd0, pwm_out}, 32'd0);
        chk("s6_ready", {31'd0, cfg_ready}, 32'd1);
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk("s6_stale_cnt", {24'd0, cnt}, 32'd0);
            chk("s6_stale_pend", {31'd0, pending}, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which sets the width of the counter, period and duty.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port en, input, 1 bit: count enable; when 0 the counter holds.
REQ-005 SHALL have port cfg_valid, input, 1 bit: new configuration offered.
REQ-006 SHALL have port cfg_ready, output, 1 bit: shadow register free; the config is accepted when cfg_valid && cfg_ready.
REQ-007 SHALL have port cfg_period, input, WIDTH bits: terminal count; the PWM period is cfg_period+1 enabled cycles.
REQ-008 SHALL have port cfg_duty, input, WIDTH bits: number of enabled cycles per period that pwm_out is high.
REQ-009 SHALL have port cnt, output, WIDTH bits: current count value.
REQ-010 SHALL have port pwm_out, output, 1 bit: PWM waveform.
REQ-011 SHALL have port wrap, output, 1 bit: period-end indication.
REQ-012 SHALL have port pending, output, 1 bit: shadow holds a config not yet applied.

Function
REQ-013 SHALL hold active registers period_q and duty_q, shadow registers period_s and duty_s, and a pending flag.
REQ-014 SHALL drive cfg_ready = !pending, combinationally.
REQ-015 SHALL, on handshake (cfg_valid && cfg_ready), capture cfg_period and cfg_duty into the shadow and set pending=1 at the next edge.
REQ-016 SHALL ignore cfg_valid while pending=1; the source holds the data until it is accepted.
REQ-017 SHALL drive wrap = en && (cnt == period_q), combinationally.
REQ-018 SHALL update the counter when en=1 as follows: if cnt==period_q then cnt<=0, else cnt<=cnt+1.
REQ-019 SHALL hold the counter when en=0.
REQ-020 SHALL, with period_q=0 and en=1, keep cnt at 0 and assert wrap on every enabled cycle.
REQ-021 SHALL, on an edge where wrap=1 and pending=1, copy the shadow into period_q/duty_q and clear pending; cnt goes to 0 per REQ-018.
REQ-022 SHALL, on an edge where en=0 and pending=1, copy the shadow into the active registers, clear pending and force cnt<=0.
REQ-023 SHALL not change period_q/duty_q at any other time, so the duty/period never changes mid-period while running.
REQ-024 SHALL drive pwm_out = (cnt < duty_q), unsigned compare, decoded from registered state only.
REQ-025 SHALL therefore produce pwm_out=0 constantly when duty_q=0, and constantly 1 when duty_q > period_q.
REQ-026 SHALL, when a handshake and a wrap occur in the same cycle with pending=0, load the new config into the shadow only; it is applied at the following wrap.
REQ-027 SHALL use modulo-2^WIDTH arithmetic; cnt never exceeds period_q while en=1 after any transfer.
REQ-028 SHALL make cfg_ready return to 1 the cycle after a transfer; a second config is accepted no earlier than that cycle.

Reset
REQ-029 SHALL, while rstn=0 at an edge, set cnt=0, period_q=0, duty_q=0, period_s=0, duty_s=0 and pending=0.
REQ-030 SHALL give the following output values after reset: pwm_out=0, cfg_ready=1, pending=0; wrap=1 only if en=1.
REQ-031 SHALL give reset priority over en and over the cfg handshake; a reset mid-period discards the shadow contents.

Verification (WIDTH=8)
REQ-032 SHALL cover: reset, then cfg period=4 duty=2, en=1 -> applied at the first wrap; cnt then runs 0,1,2,3,4,0; pwm_out is 1,1,0,0,0; wrap is high at cnt=4.
REQ-033 SHALL cover: running period=9 duty=3, cfg duty=7 offered at cnt=5 -> pending=1 and cfg_ready=0; pwm_out keeps duty 3 until cnt=9; from cnt=0 it is high for 7 cycles; cfg_ready=1 at cnt=1.
REQ-034 SHALL cover: duty=0 -> pwm_out stays 0 over 3 periods; duty=10 with period=9 -> pwm_out stays 1; duty=255 -> pwm_out stays 1.
REQ-035 SHALL cover: en=0 with cnt=6, cfg period=3 duty=1 -> next edge gives pending=0 and cnt=0; after en=1 the sequence is 0,1,2,3,0 and pwm_out is high only at cnt=0.
REQ-036 SHALL cover: two back-to-back cfg_valid beats -> the second is stalled (cfg_ready=0) until the cycle after the first is applied, then accepted and applied at the next wrap.
REQ-037 SHALL cover: rstn=0 at cnt=7 with pending=1 -> next edge gives cnt=0, pending=0, pwm_out=0 and cfg_ready=1; the stale shadow is never applied.
